// File: rtl/interp_sequencer.sv
// Select/strobe sequencer for the 8x8 HEVC sub-pixel interpolation datapath.
// Optional completed-block counter is built when INTERP_PERF_CNT_EN is defined.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start, sel parked at 0
// S_HPASS | issuing integer rows 0..ROWS-1 for the horizontal pass
// S_VPASS | issuing column-group selects ROWS..LAST_SEL
// S_DRAIN | holding sel at LAST_SEL while the FIR pipeline empties
// S_VALID | result buffers stable, waiting for out_ack
module interp_sequencer #(
    parameter int NUM_PIXEL = 8,
    parameter int FIR_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        out_ack,
    output logic [7:0]  sel,
    output logic        fb_we,
    output logic [7:0]  fb_row,
    output logic        cap_we,
    output logic [5:0]  cap_slot,
    output logic        busy,
    output logic        out_valid,
    output logic [15:0] blk_count
);

    localparam int ROWS     = NUM_PIXEL + 7;
    localparam int VCOLS    = 4 * NUM_PIXEL;
    localparam int LAST_SEL = ROWS + VCOLS - 1;

    localparam logic [7:0] ROWS_B     = 8'(ROWS);
    localparam logic [7:0] ROW_END_B  = 8'(ROWS - 1);
    localparam logic [7:0] LAST_B     = 8'(LAST_SEL);
    localparam logic [7:0] CAP_H_LO   = 8'd3;
    localparam logic [7:0] CAP_H_HI   = 8'(2 + NUM_PIXEL);
    localparam logic [7:0] V_SLOT_OFS = 8'(ROWS - NUM_PIXEL);
    localparam logic [2:0] DRAIN_LD   = 3'(FIR_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HPASS,
        S_VPASS,
        S_DRAIN,
        S_VALID
    } state_t;

    state_t     state;
    logic [2:0] drain_cnt;
    logic       issued;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            sel       <= 8'd0;
            drain_cnt <= 3'd0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else if (abort) begin
            state     <= S_IDLE;
            sel       <= 8'd0;
            drain_cnt <= 3'd0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_HPASS;
                        busy  <= 1'b1;
                    end
                end
                S_HPASS: begin
                    sel <= sel + 8'd1;
                    if (sel == ROW_END_B)
                        state <= S_VPASS;
                end
                S_VPASS: begin
                    if (sel == LAST_B) begin
                        state     <= S_DRAIN;
                        drain_cnt <= DRAIN_LD;
                    end else begin
                        sel <= sel + 8'd1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 3'd0) begin
                        state     <= S_VALID;
                        out_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                S_VALID: begin
                    // A start seen together with the ack is deliberately dropped.
                    if (out_ack) begin
                        state     <= S_IDLE;
                        sel       <= 8'd0;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    sel       <= 8'd0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign issued = (state == S_HPASS) || (state == S_VPASS);

    // Delay line re-times each issued select to the moment its FIR result appears.
    logic [FIR_LAT-1:0] dl_v;
    logic [7:0]         dl_sel [FIR_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_v <= '0;
            for (int i = 0; i < FIR_LAT; i++)
                dl_sel[i] <= 8'd0;
        end else if (abort) begin
            dl_v <= '0;
            for (int i = 0; i < FIR_LAT; i++)
                dl_sel[i] <= 8'd0;
        end else begin
            dl_v[0]   <= issued;
            dl_sel[0] <= sel;
            for (int i = 1; i < FIR_LAT; i++) begin
                dl_v[i]   <= dl_v[i-1];
                dl_sel[i] <= dl_sel[i-1];
            end
        end
    end

    logic       d_v;
    logic [7:0] d_sel;
    logic       cap_h;
    logic       cap_v;

    assign d_v   = dl_v[FIR_LAT-1];
    assign d_sel = dl_sel[FIR_LAT-1];

    assign fb_we  = d_v && (d_sel < ROWS_B);
    assign fb_row = d_sel;

    assign cap_h  = d_v && (d_sel >= CAP_H_LO) && (d_sel <= CAP_H_HI);
    assign cap_v  = d_v && (d_sel >= ROWS_B);
    assign cap_we = cap_h || cap_v;

    always_comb begin
        cap_slot = 6'd0;
        if (cap_h)
            cap_slot = 6'(d_sel - CAP_H_LO);
        else if (cap_v)
            cap_slot = 6'(d_sel - V_SLOT_OFS);
    end

`ifdef INTERP_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            blk_count <= 16'h0000;
        else if (!abort && (state == S_VALID) && out_ack && (blk_count != 16'hFFFF))
            blk_count <= blk_count + 16'h0001;
    end
`else
    assign blk_count = 16'h0000;
`endif

endmodule

// File: doc/interp_sequencer.md
# interp_sequencer

Control sequencer for the 8x8 HEVC sub-pixel interpolation datapath. On a start request it steps the input-mux select through the horizontal pass (NUM_PIXEL+7 integer rows), then the vertical pass (4 column groups x NUM_PIXEL). It also issues FIR-latency-aligned write strobes to the feedback shift registers and to the output fillers. It sits beside the FIR_A/B/C array, replaces the free-running counter/select register pair, and presents a start/valid/ack handshake to the block fetch and store logic.

## Interface
- NUM_PIXEL, 8, block edge in pixels; ROWS = NUM_PIXEL+7, VCOLS = 4*NUM_PIXEL, LAST_SEL = ROWS+VCOLS-1 (46)
- FIR_LAT, 1, FIR pipeline latency in cycles, legal 1..4
- clk  in  1  clock; everything is sampled on the rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin one block; sampled only in IDLE
- abort  in  1  cancel the current block; wins over every other input
- out_ack  in  1  consumer accepted the result
- sel  out  8  input-mux row/column select
- fb_we  out  1  feedback shift-register write strobe (drives load_L = ~fb_we)
- fb_row  out  8  row index of the FIR result currently at the FIR output
- cap_we  out  1  output-filler capture strobe
- cap_slot  out  6  output-filler slot, 0..39
- busy  out  1  high in any state except IDLE
- out_valid  out  1  high in VALID; result buffers are stable while it is high
- blk_count  out  16  completed-block counter (see Configuration)

## Operation
- States: IDLE, HPASS, VPASS, DRAIN, VALID.
- IDLE: sel=0. If start=1, go to HPASS; sel=0 is issued in the first HPASS cycle.
- HPASS: issue sel = 0..ROWS-1, one per cycle. After issuing ROWS-1, go to VPASS.
- VPASS: issue sel = ROWS..LAST_SEL, one per cycle. After issuing LAST_SEL, go to DRAIN.
- DRAIN: hold sel at LAST_SEL for FIR_LAT cycles, then go to VALID.
- VALID: hold until out_ack=1, then go to IDLE. start is ignored in every state except IDLE.
- Align pipeline: a delay line FIR_LAT stages deep carries {issued, sel}. Its output {d_v, d_sel} drives all strobes.
  - fb_we = d_v && d_sel < ROWS; fb_row = d_sel.
  - cap_we = d_v && ((3 <= d_sel <= 2+NUM_PIXEL) || d_sel >= ROWS).
  - cap_slot = d_sel-3 for horizontal captures, d_sel-ROWS+NUM_PIXEL for vertical captures. This gives slots 0..7 and 8..39.
- Rows 0-2 and 11-14 are written to the feedback registers but never captured.
- abort=1 in any state: next state is IDLE and the delay line is cleared, so no strobes follow the abort. out_valid is not asserted and blk_count is not incremented.
- Simultaneous out_ack and start in VALID: the ack completes the block. The start is not accepted; it must be presented again in IDLE.
- sel is 8 bits wide with no wrap. LAST_SEL < 256 holds for NUM_PIXEL <= 8.

## Timing
- Reset values: state=IDLE, sel=0, fb_we=0, fb_row=0, cap_we=0, cap_slot=0, busy=0, out_valid=0, blk_count=0. The delay line is cleared.
- Assertion of rst mid-block takes effect immediately (asynchronous) and behaves like abort.
- All outputs are registered or decoded from registered state only. No input reaches an output combinationally.
- With start sampled at edge T:
  - sel=0 from T+1, sel=LAST_SEL at T+47.
  - First fb_we at T+1+FIR_LAT; last cap_we at T+47+FIR_LAT.
  - out_valid from T+48+FIR_LAT.
- Block period is 49+FIR_LAT cycles with out_ack tied high and start held high.
- busy rises at T+1 and falls the cycle after out_ack is sampled in VALID.

## Configuration
- INTERP_PERF_CNT_EN defined: blk_count increments by 1 on each VALID to IDLE transition caused by out_ack, and saturates at 16'hFFFF. Aborted blocks are not counted.
- INTERP_PERF_CNT_EN undefined: the counter logic is absent and blk_count is tied to 16'h0000. All other behaviour is identical.

## Test plan
- Reset then one start pulse, FIR_LAT=1, out_ack held low: sel steps 0..46 on cycles 1..47; fb_we is high on cycles 2..16 with fb_row 0..14; out_valid rises at cycle 49 and holds.
- Capture map, FIR_LAT=2: cap_we is seen exactly 40 times. d_sel 3..10 maps to slots 0..7 and d_sel 15..46 maps to slots 8..39, with no duplicate slots.
- abort at cycle 20 (in VPASS): the next cycle is IDLE, busy=0, no further fb_we/cap_we, out_valid never rises, blk_count unchanged.
- start held high with out_ack tied high: back-to-back blocks every 50 cycles (FIR_LAT=1); blk_count = 3 after three blocks with the macro defined, and 0 without it.
- rst asserted during DRAIN: all outputs return to their reset values immediately. A following start produces a full, normal block.
- In VALID, start and out_ack are asserted in the same cycle: the design goes to IDLE with no new block; start asserted again one cycle later launches a block.
